// File: rtl/combo_bist_checker.sv
// Built-in self-test sequencer for a small combinational block: it walks every
// input vector, samples the block output after a settle delay and scores it against TRUTH.
module combo_bist_checker #(
  parameter int                      N_IN   = 2,
  parameter int                      SETTLE = 1,
  parameter logic [(1<<N_IN)-1:0]    TRUTH  = 4'b1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_idx
);

  localparam int IDX_W = N_IN + 1;
  localparam int NVEC  = 1 << N_IN;
  localparam int WC_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NVEC - 1);
  localparam logic [IDX_W-1:0] ONE_IDX   = IDX_W'(1);
  localparam logic [WC_W-1:0]  WAIT_INIT = WC_W'(SETTLE - 1);
  localparam logic [WC_W-1:0]  ONE_WC    = WC_W'(1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRIVE  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic [2:0]       state_r;
  logic [2:0]       state_nxt_s;
  logic [IDX_W-1:0] idx_r;
  logic [WC_W-1:0]  wait_cnt_r;
  logic [N_IN-1:0]  dut_in_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;
  logic [N_IN:0]    err_count_r;
  logic             ff_valid_r;
  logic [N_IN-1:0]  ff_idx_r;
  logic             mismatch_s;

  // Expected block output for a given vector index; the extra idx bit never selects.
  function automatic logic expected_bit(input logic [IDX_W-1:0] i);
    return TRUTH[i[N_IN-1:0]];
  endfunction

  // Next-state decode and mismatch detection for the current vector.
  always_comb begin
    mismatch_s  = (dut_out != expected_bit(idx_r));
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) state_nxt_s = ST_DRIVE;
        else       state_nxt_s = state_r;
      end
      ST_DRIVE: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (wait_cnt_r == '0) state_nxt_s = ST_SAMPLE;
        else                  state_nxt_s = ST_WAIT;
      end
      ST_SAMPLE: begin
        if (idx_r == LAST_IDX) state_nxt_s = ST_DONE;
        else                   state_nxt_s = ST_DRIVE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Sequencer state, vector stepping and result scoreboard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      idx_r       <= '0;
      wait_cnt_r  <= '0;
      dut_in_r    <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      err_count_r <= '0;
      ff_valid_r  <= 1'b0;
      ff_idx_r    <= '0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            idx_r       <= '0;
            err_count_r <= '0;
            ff_valid_r  <= 1'b0;
            ff_idx_r    <= '0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            busy_r      <= 1'b1;
          end else if (state_r == ST_DONE) begin
            // err_count already includes the last vector's result here.
            busy_r <= 1'b0;
            done_r <= 1'b1;
            pass_r <= (err_count_r == '0);
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_DRIVE: begin
          dut_in_r   <= idx_r[N_IN-1:0];
          wait_cnt_r <= WAIT_INIT;
        end
        ST_WAIT: begin
          if (wait_cnt_r != '0) wait_cnt_r <= wait_cnt_r - ONE_WC;
          else                  wait_cnt_r <= wait_cnt_r;
        end
        ST_SAMPLE: begin
          if (mismatch_s) begin
            err_count_r <= err_count_r + ONE_IDX;
            if (!ff_valid_r) begin
              ff_valid_r <= 1'b1;
              ff_idx_r   <= idx_r[N_IN-1:0];
            end else begin
              ff_valid_r <= ff_valid_r;
            end
          end else begin
            err_count_r <= err_count_r;
          end
          if (idx_r != LAST_IDX) idx_r <= idx_r + ONE_IDX;
          else                   idx_r <= idx_r;
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign dut_in           = dut_in_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign pass             = pass_r;
  assign err_count        = err_count_r;
  assign first_fail_valid = ff_valid_r;
  assign first_fail_idx   = ff_idx_r;

endmodule

// File: tb/tb_combo_bist_checker.sv
// Directed bench: default 2-input AND checker with fault modes, plus a 3-input XOR instance.
module tb_combo_bist_checker;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b;
  int   mode_a;
  logic flip_b;

  logic [1:0] dut_in_a;
  logic       dut_out_a, busy_a, done_a, pass_a, ffv_a;
  logic [2:0] err_a;
  logic [1:0] ffi_a;

  logic [2:0] dut_in_b;
  logic       dut_out_b, busy_b, done_b, pass_b, ffv_b;
  logic [3:0] err_b;
  logic [2:0] ffi_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Block under test models: good AND, stuck-at-0, stuck-at-1; XOR with optional fault at 5.
  assign dut_out_a = (mode_a == 0) ? (&dut_in_a) : (mode_a == 1) ? 1'b0 : 1'b1;
  assign dut_out_b = (^dut_in_b) ^ (flip_b && (dut_in_b == 3'd5));

  combo_bist_checker u_a (
    .clk(clk), .rst(rst), .start(start_a), .dut_in(dut_in_a), .dut_out(dut_out_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_fail_valid(ffv_a), .first_fail_idx(ffi_a)
  );

  combo_bist_checker #(.N_IN(3), .SETTLE(3), .TRUTH(8'b1001_0110)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .dut_in(dut_in_b), .dut_out(dut_out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_fail_valid(ffv_b), .first_fail_idx(ffi_b)
  );

  typedef struct {
    int   mode;
    int   exp_cyc;
    logic exp_pass;
    int   exp_err;
    logic exp_ffv;
    int   exp_ffi;
    int   extra_start;
  } row_t;

  row_t tbl [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Start a run on instance a; optionally pulse start again at cycle extra_at.
  task automatic run_a(input int extra_at, output int cyc);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    cyc = 0;
    while (!done_a && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      start_a = (cyc == extra_at - 1) ? 1'b1 : 1'b0;
      if (cyc == 1) begin
        chk("busy_in_run", 32'(busy_a), 32'd1);
        chk("done_cleared", 32'(done_a), 32'd0);
        chk("err_cleared", 32'(err_a), 32'd0);
      end
      if ((cyc % 3 == 1) && (cyc <= 10))
        chk("dut_in_step", 32'(dut_in_a), 32'(cyc / 3));
    end
    start_a = 1'b0;
  endtask

  task automatic run_b(output int cyc);
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    cyc = 0;
    while (!done_b && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    tbl[0] = '{mode: 0, exp_cyc: 13, exp_pass: 1'b1, exp_err: 0, exp_ffv: 1'b0, exp_ffi: 0, extra_start: -1};
    tbl[1] = '{mode: 1, exp_cyc: 13, exp_pass: 1'b0, exp_err: 1, exp_ffv: 1'b1, exp_ffi: 3, extra_start: -1};
    tbl[2] = '{mode: 2, exp_cyc: 13, exp_pass: 1'b0, exp_err: 3, exp_ffv: 1'b1, exp_ffi: 0, extra_start: -1};
    tbl[3] = '{mode: 0, exp_cyc: 13, exp_pass: 1'b1, exp_err: 0, exp_ffv: 1'b0, exp_ffi: 0, extra_start: 5};

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; mode_a = 0; flip_b = 1'b0;
    #22;
    chk("rst_dut_in", 32'(dut_in_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_pass", 32'(pass_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    chk("rst_ffv", 32'(ffv_a), 32'd0);
    chk("rst_ffi", 32'(ffi_a), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back runs without reset: each restart must clear the previous results.
    for (int i = 0; i < 4; i++) begin
      mode_a = tbl[i].mode;
      run_a(tbl[i].extra_start, cyc);
      chk("done_latency", 32'(cyc), 32'(tbl[i].exp_cyc));
      chk("pass", 32'(pass_a), 32'(tbl[i].exp_pass));
      chk("err_count", 32'(err_a), 32'(tbl[i].exp_err));
      chk("ff_valid", 32'(ffv_a), 32'(tbl[i].exp_ffv));
      chk("ff_idx", 32'(ffi_a), 32'(tbl[i].exp_ffi));
      chk("busy_at_done", 32'(busy_a), 32'd0);
      @(posedge clk); #1;
      chk("done_held", 32'(done_a), 32'd1);
      chk("dut_in_held", 32'(dut_in_a), 32'd3);
    end

    // Asynchronous reset during WAIT of vector 2, with a stuck-at-0 fault pending.
    mode_a = 1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("pre_rst_dut_in", 32'(dut_in_a), 32'd2);
    chk("pre_rst_busy", 32'(busy_a), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_dut_in", 32'(dut_in_a), 32'd0);
    chk("arst_busy", 32'(busy_a), 32'd0);
    chk("arst_done", 32'(done_a), 32'd0);
    chk("arst_err", 32'(err_a), 32'd0);
    chk("arst_ffv", 32'(ffv_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mode_a = 0;
    @(posedge clk); #1;
    chk("idle_after_rst", 32'(busy_a), 32'd0);
    run_a(-1, cyc);
    chk("post_rst_latency", 32'(cyc), 32'd13);
    chk("post_rst_pass", 32'(pass_a), 32'd1);
    chk("post_rst_err", 32'(err_a), 32'd0);

    // Three-input XOR instance, good then with a fault on vector 5.
    flip_b = 1'b0;
    run_b(cyc);
    chk("xor_latency", 32'(cyc), 32'd41);
    chk("xor_pass", 32'(pass_b), 32'd1);
    chk("xor_err", 32'(err_b), 32'd0);
    chk("xor_ffv", 32'(ffv_b), 32'd0);
    chk("xor_busy", 32'(busy_b), 32'd0);
    flip_b = 1'b1;
    run_b(cyc);
    chk("xor_f_latency", 32'(cyc), 32'd41);
    chk("xor_f_pass", 32'(pass_b), 32'd0);
    chk("xor_f_err", 32'(err_b), 32'd1);
    chk("xor_f_ffv", 32'(ffv_b), 32'd1);
    chk("xor_f_ffi", 32'(ffi_b), 32'd5);
    chk("xor_f_dut_in", 32'(dut_in_b), 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
